// File: rtl/round_sequencer_pkg.sv
// Shared types for the round sequencer: FSM state encodings and coordinate widths.
// No logic; imported by the sequencer and its window calculator.
// No flow control of its own.
package round_sequencer_pkg;

    localparam int PIX_W = 8;
    localparam int Z_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_KICK  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ADV   = 3'd5,
        ST_FIN   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/round_sequencer_seq_window_calc.sv
// Window calculator: last output position of a round, padded window ends, output count, last-round flag.
// Purely combinational; registered by the sequencer in LOAD.
// No flow control.
module seq_window_calc
    import round_sequencer_pkg::*;
#(
    parameter int N_ALLOC = 4
) (
    input  logic [PIX_W-1:0] ox,
    input  logic [PIX_W-1:0] oy,
    input  logic [PIX_W-1:0] dim,
    input  logic [1:0]       pad,
    output logic [PIX_W-1:0] x_end,
    output logic [PIX_W-1:0] y_max,
    output logic [PIX_W-1:0] count,
    output logic             is_last
);

    localparam logic [PIX_W:0] N_M1 = (PIX_W+1)'(N_ALLOC - 1);

    logic [PIX_W:0]   sum_x;
    logic [PIX_W-1:0] lx_w, ly_w, lx_c, ly_c, pad2, dim_m1;

    always_comb begin
        pad2   = {5'b0, pad, 1'b0};
        dim_m1 = dim - 8'd1;
        // 9-bit sum: ox+N-1 can exceed 255 on wide images
        sum_x  = {1'b0, ox} + N_M1;
        lx_w   = sum_x[PIX_W-1:0];
        ly_w   = oy;
        if (sum_x >= {1'b0, dim}) begin
            lx_w = PIX_W'(sum_x - {1'b0, dim});
            ly_w = oy + 8'd1;
        end
        lx_c  = lx_w;
        ly_c  = ly_w;
        count = PIX_W'(N_ALLOC);
        // Running off the bottom row means this is a short final round
        if (ly_w >= dim) begin
            lx_c  = dim_m1;
            ly_c  = dim_m1;
            count = dim - ox;
        end
        is_last = (lx_c == dim_m1) && (ly_c == dim_m1);
        x_end   = lx_c + pad2;
        y_max   = ly_c + pad2;
    end

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer: steps N_ALLOC-wide issue rounds over an image, restarting the broadcaster per round.
// Latency: LOAD, KICK, then RUN/DRAIN wait on broadcaster and allocators, ADV; FIN pulses done.
// Backpressure: stalls in RUN until bcast_round, in DRAIN until alloc_done. Optional SEQ_STALL_CNT_EN.
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int N_ALLOC = 4,
    parameter int RIDX_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        image_dim,
    input  logic [1:0]        image_padding,
    input  logic              bcast_round,
    input  logic              bcast_block,
    input  logic              alloc_done,
    output logic [7:0]        x_min,
    output logic [7:0]        x_max,
    output logic [7:0]        x_start,
    output logic [7:0]        x_end,
    output logic [7:0]        y_min,
    output logic [7:0]        y_max,
    output logic              bcast_rst,
    output logic              alloc_load,
    output logic [7:0]        out_x,
    output logic [7:0]        out_y,
    output logic [7:0]        out_count,
    output logic [RIDX_W-1:0] round_idx,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [31:0]       stall_count
);

    seq_state_t state, nxt;

    logic [PIX_W-1:0] dim_q, ox, oy;
    logic [1:0]       pad_q;
    logic             last_q, abort_q;
    logic [9:0]       padded;
    logic             cfg_bad;
    logic [PIX_W:0]   ox_nx;
    logic [PIX_W-1:0] c_x_end, c_y_max, c_count;
    logic             c_last;

    seq_window_calc #(.N_ALLOC(N_ALLOC)) u_calc (
        .ox      (ox),
        .oy      (oy),
        .dim     (dim_q),
        .pad     (pad_q),
        .x_end   (c_x_end),
        .y_max   (c_y_max),
        .count   (c_count),
        .is_last (c_last)
    );

    assign padded  = {2'b0, image_dim} + {7'b0, image_padding, 1'b0};
    assign cfg_bad = (image_dim == 8'd0) || (int'(image_dim) < N_ALLOC) || (padded > 10'd255);
    assign ox_nx   = {1'b0, ox} + (PIX_W+1)'(N_ALLOC);
    assign x_min   = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (start && !cfg_bad) nxt = ST_LOAD;
            ST_LOAD:  nxt = ST_KICK;
            ST_KICK:  nxt = ST_RUN;
            ST_RUN:   if (bcast_round) nxt = ST_DRAIN;
            ST_DRAIN: if (alloc_done) nxt = ST_ADV;
            ST_ADV:   nxt = last_q ? ST_FIN : ST_LOAD;
            ST_FIN:   nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) nxt = ST_IDLE;
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        done       = (state == ST_FIN);
        alloc_load = (state == ST_KICK);
        bcast_rst  = (state == ST_KICK) || abort_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dim_q     <= '0;
            pad_q     <= '0;
            ox        <= '0;
            oy        <= '0;
            round_idx <= '0;
            last_q    <= 1'b0;
            abort_q   <= 1'b0;
            cfg_err   <= 1'b0;
            x_max     <= '0;
            x_start   <= '0;
            x_end     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_count <= '0;
        end else begin
            // Abort restarts the broadcaster on the cycle the FSM lands in IDLE
            abort_q <= abort && (state != ST_IDLE);
            if (state == ST_IDLE && start) begin
                dim_q <= image_dim;
                pad_q <= image_padding;
                if (cfg_bad) begin
                    cfg_err <= 1'b1;
                end else begin
                    ox        <= '0;
                    oy        <= '0;
                    round_idx <= '0;
                    x_max     <= padded[7:0] - 8'd1;
                end
            end
            if (state == ST_LOAD) begin
                x_start   <= ox;
                x_end     <= c_x_end;
                y_min     <= oy;
                y_max     <= c_y_max;
                out_x     <= ox;
                out_y     <= oy;
                out_count <= c_count;
                last_q    <= c_last;
            end
            if (state == ST_ADV && !last_q) begin
                round_idx <= round_idx + RIDX_W'(1);
                if (ox_nx >= {1'b0, dim_q}) begin
                    ox <= PIX_W'(ox_nx - {1'b0, dim_q});
                    oy <= oy + 8'd1;
                end else begin
                    ox <= ox_nx[PIX_W-1:0];
                end
            end
        end
    end

`ifdef SEQ_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_q <= '0;
        end else if (state == ST_RUN && bcast_block && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    logic unused_bcast_block;

    assign unused_bcast_block = bcast_block;
    assign stall_count        = '0;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: full images, short last round, abort, config errors, stall count.
module tb_round_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, bcast_round, bcast_block, alloc_done;
    logic [7:0]  image_dim;
    logic [1:0]  image_padding;
    logic [7:0]  x_min, x_max, x_start, x_end, y_min, y_max, out_x, out_y, out_count;
    logic        bcast_rst, alloc_load, busy, done, cfg_err;
    logic [15:0] round_idx;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    round_sequencer #(.N_ALLOC(4), .RIDX_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .image_dim     (image_dim),
        .image_padding (image_padding),
        .bcast_round   (bcast_round),
        .bcast_block   (bcast_block),
        .alloc_done    (alloc_done),
        .x_min         (x_min),
        .x_max         (x_max),
        .x_start       (x_start),
        .x_end         (x_end),
        .y_min         (y_min),
        .y_max         (y_max),
        .bcast_rst     (bcast_rst),
        .alloc_load    (alloc_load),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_count     (out_count),
        .round_idx     (round_idx),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .stall_count   (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load();
        int guard = 0;
        while (alloc_load !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) check("load_timeout", 32'd0, 32'd1);
    endtask

    // Reference window from linear position arithmetic, N_ALLOC = 4
    task automatic check_window(input int dim, input int pad, input int r);
        int p0, pl;
        p0 = r * 4;
        pl = p0 + 3;
        if (pl > dim * dim - 1) pl = dim * dim - 1;
        check("round_idx", round_idx, r);
        check("x_start",   x_start,   p0 % dim);
        check("x_end",     x_end,     (pl % dim) + 2 * pad);
        check("y_min",     y_min,     p0 / dim);
        check("y_max",     y_max,     (pl / dim) + 2 * pad);
        check("out_x",     out_x,     p0 % dim);
        check("out_y",     out_y,     p0 / dim);
        check("out_count", out_count, pl - p0 + 1);
        check("x_max",     x_max,     dim + 2 * pad - 1);
        check("x_min",     x_min,     0);
        check("bcast_rst_kick", bcast_rst, 1);
    endtask

    // Runs one round from KICK through ADV; ends one cycle after ADV
    task automatic do_round(input int dim, input int pad, input int r, input bit blk);
        wait_load();
        check_window(dim, pad, r);
        if (dim == 8 && r == 0) begin
            check("t1_x_end", x_end, 5);
            check("t1_y_max", y_max, 2);
            check("t1_x_max", x_max, 9);
        end
        if (dim == 6 && r == 1) begin
            check("t2_x_start", x_start, 4);
            check("t2_x_end",   x_end,   3);
            check("t2_y_min",   y_min,   0);
            check("t2_y_max",   y_max,   3);
        end
        if (dim == 5 && r == 6) begin
            check("t3_out_x",   out_x,     4);
            check("t3_out_y",   out_y,     4);
            check("t3_count",   out_count, 1);
            check("t3_x_start", x_start,   4);
            check("t3_x_end",   x_end,     8);
            check("t3_y_min",   y_min,     4);
            check("t3_y_max",   y_max,     8);
        end
        step();
        bcast_block = blk;
        repeat (blk ? 7 : 1) step();
        bcast_block = 1'b0;
        bcast_round = 1'b1;
        step();
        bcast_round = 1'b0;
        alloc_done  = 1'b1;
        step();
        alloc_done = 1'b0;
        check("busy_adv", busy, 1);
        step();
    endtask

    task automatic run_image(input int dim, input int pad, input int rounds, input bit blk);
        image_dim     = 8'(dim);
        image_padding = 2'(pad);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r < rounds; r++) begin
            do_round(dim, pad, r, blk && (r == 0));
            check("done_pulse", done, (r == rounds - 1) ? 1 : 0);
        end
        step();
        check("busy_end", busy, 0);
        check("done_end", done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; bcast_round = 1'b0;
        bcast_block = 1'b0; alloc_done = 1'b0; image_dim = 8'd0; image_padding = 2'd0;
        step();
        check("rst_busy",   busy,        0);
        check("rst_done",   done,        0);
        check("rst_x_max",  x_max,       0);
        check("rst_brst",   bcast_rst,   0);
        check("rst_ridx",   round_idx,   0);
        check("rst_cfg",    cfg_err,     0);
        check("rst_stall",  stall_count, 0);
        check("rst_count",  out_count,   0);
        rst = 1'b0;
        step();

        run_image(8, 1, 16, 1'b0);
        check("stall_none", stall_count, 0);
        run_image(6, 1, 9, 1'b0);
        run_image(5, 2, 7, 1'b0);

        // Abort in DRAIN of round 2, alloc_done in the same cycle must lose
        image_dim = 8'd8; image_padding = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        do_round(8, 1, 0, 1'b0);
        do_round(8, 1, 1, 1'b0);
        wait_load();
        check("ab_ridx", round_idx, 2);
        step();
        step();
        bcast_round = 1'b1;
        step();
        bcast_round = 1'b0;
        abort = 1'b1;
        alloc_done = 1'b1;
        step();
        abort = 1'b0;
        alloc_done = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_brst", bcast_rst, 1);
        check("ab_done", done, 0);
        step();
        check("ab_brst_off", bcast_rst, 0);
        check("ab_done2", done, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_load();
        check("ab_restart_ridx", round_idx, 0);
        check("ab_restart_x", out_x, 0);
        check("ab_restart_y", out_y, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_kick_busy", busy, 0);
        step();

        run_image(4, 1, 4, 1'b1);
`ifdef SEQ_STALL_CNT_EN
        check("stall_7", stall_count, 7);
`else
        check("stall_off", stall_count, 0);
`endif

        // N_ALLOC > dim
        image_dim = 8'd3; image_padding = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("cfg_n_err", cfg_err, 1);
        check("cfg_n_busy", busy, 0);
        step();
        check("cfg_n_busy2", busy, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cfg_rst_clear", cfg_err, 0);

        // Padded width 256 overflows the coordinate range
        image_dim = 8'd252; image_padding = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        check("cfg_wide_err", cfg_err, 1);
        check("cfg_wide_busy", busy, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        image_dim = 8'd0; image_padding = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("cfg_zero_err", cfg_err, 1);
        check("cfg_zero_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
